uart_tx_slave: RTL and testbench

UART_TX_SLAVE -- requirements
Module: uart_tx_slave

---
 rtl/uart_tx_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_slave.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_slave.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divider, 8N1 framing.
// Optional interrupt output enabled by defining UART_TX_IRQ_EN.
module uart_tx_slave #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s1_waddr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_we,
    input  logic [31:0] s1_raddr,
    output logic [31:0] s1_rdata,
    output logic        uart_txd,
    output logic        irq_o
);

    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    // Register state
    logic [15:0]   bauddiv_q;
    logic          en_q;
    logic          ie_q;
    logic          ovf_q;

    // FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [4:0]    level_q;

    // Transmitter state
    state_t        state_q;
    logic [7:0]    shreg_q;
    logic [15:0]   div_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_q;
    logic          txd_q;

    logic          wr_en;
    logic [1:0]    wsel, rsel;
    logic          push_req, push_ok, pop;
    logic          stat_wr, baud_wr, ctrl_wr;
    logic [15:0]   baud_new;
    logic          full, empty, busy;
    logic [7:0]    head;
    logic          unused;

    assign unused = ^{s1_waddr[31:4], s1_waddr[1:0], s1_raddr[31:4], s1_raddr[1:0],
                      s1_wdata[31:16]};

    assign wr_en    = |s1_we;
    assign wsel     = s1_waddr[3:2];
    assign rsel     = s1_raddr[3:2];
    assign push_req = wr_en && (wsel == 2'd0) && s1_we[0];
    assign stat_wr  = wr_en && (wsel == 2'd1) && s1_we[0];
    assign baud_wr  = wr_en && (wsel == 2'd2) && (s1_we[0] || s1_we[1]);
    assign ctrl_wr  = wr_en && (wsel == 2'd3) && s1_we[0];

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == 5'd0);
    assign busy  = (state_q != StIdle);
    assign head  = mem[rptr_q];

    // Pop on idle, or straight out of the last stop-bit cycle so frames abut.
    assign pop = en_q && !empty &&
                 ((state_q == StIdle) || ((state_q == StStop) && (cnt_q == 16'd0)));
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        baud_new = bauddiv_q;
        if (s1_we[0]) baud_new[7:0] = s1_wdata[7:0];
        if (s1_we[1]) baud_new[15:8] = s1_wdata[15:8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bauddiv_q <= DIV_RST;
            en_q      <= 1'b0;
        end else begin
            if (baud_wr) bauddiv_q <= (baud_new == 16'd0) ? 16'd1 : baud_new;
            if (ctrl_wr) en_q <= s1_wdata[0];
        end
    end

    // Overflow set beats a same-cycle W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_q <= 1'b1;
        end else if (stat_wr && s1_wdata[3]) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= s1_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= 5'd0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + 5'd1;
                2'b01:   level_q <= level_q - 5'd1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Divider is latched at pop so BAUDDIV writes only affect the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= 8'd0;
            div_q   <= 16'd1;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StStart;
                        shreg_q <= head;
                        div_q   <= bauddiv_q;
                        cnt_q   <= bauddiv_q - 16'd1;
                        txd_q   <= 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= StData;
                        txd_q   <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[7:1]};
                        cnt_q   <= div_q - 16'd1;
                        bit_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shreg_q[0];
                            shreg_q <= {1'b0, shreg_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == 16'd0) begin
                        if (pop) begin
                            state_q <= StStart;
                            shreg_q <= head;
                            div_q   <= bauddiv_q;
                            cnt_q   <= bauddiv_q - 16'd1;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign uart_txd = txd_q;

`ifdef UART_TX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= s1_wdata[1];
            irq_q <= (empty & ie_q & ~busy) | (ovf_q & ie_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign ie_q  = 1'b0;
    assign irq_o = 1'b0;
`endif

    always_comb begin
        s1_rdata = 32'd0;
        unique case (rsel)
            2'd0: s1_rdata = 32'd0;
            2'd1: s1_rdata = {23'd0, level_q, ovf_q, empty, full, busy};
            2'd2: s1_rdata = {16'd0, bauddiv_q};
            2'd3: s1_rdata = {30'd0, ie_q, en_q};
            default: s1_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed self-checking bench for uart_tx_slave (default FIFO_DEPTH=8, DIV_RST=434).
module tb_uart_tx_slave;

    logic        clk;
    logic        rst;
    logic [31:0] s1_waddr;
    logic [31:0] s1_wdata;
    logic [3:0]  s1_we;
    logic [31:0] s1_raddr;
    logic [31:0] s1_rdata;
    logic        uart_txd;
    logic        irq_o;

    int nvec;
    int nerr;

    uart_tx_slave dut (
        .clk      (clk),
        .rst      (rst),
        .s1_waddr (s1_waddr),
        .s1_wdata (s1_wdata),
        .s1_we    (s1_we),
        .s1_raddr (s1_raddr),
        .s1_rdata (s1_rdata),
        .uart_txd (uart_txd),
        .irq_o    (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level k cycles into a frame of divider div.
    function automatic logic exp_txd(input logic [7:0] d, input int div, input int k);
        int b;
        b = k / div;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        @(negedge clk);
        s1_waddr = a;
        s1_wdata = d;
        s1_we    = we;
        @(posedge clk);
        #1;
        s1_we = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        s1_raddr = a;
        #1;
        d = s1_rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        s1_we = 4'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++; if (uart_txd !== 1'b1) begin nerr++;
            $display("FAIL reset_txd: got %b expected 1", uart_txd); end
        nvec++; if (irq_o !== 1'b0) begin nerr++;
            $display("FAIL reset_irq: got %b expected 0", irq_o); end
        rd(32'h4, d);
        nvec++; if (d !== 32'h4) begin nerr++;
            $display("FAIL reset_status: got %h expected 00000004", d); end
        rd(32'h8, d);
        nvec++; if (d !== 32'd434) begin nerr++;
            $display("FAIL reset_bauddiv: got %h expected %h", d, 32'd434); end
        rd(32'hC, d);
        nvec++; if (d !== 32'h0) begin nerr++;
            $display("FAIL reset_ctrl: got %h expected 00000000", d); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_frame();
        logic e;
        wr(32'h8, 32'd4, 4'hF);
        wr(32'hC, 32'h1, 4'hF);
        wr(32'h0, 32'h55, 4'h1);
        s1_raddr = 32'h4;
        #1;
        nvec++; if (uart_txd !== 1'b1) begin nerr++;
            $display("FAIL frame_pre_start: got %b expected 1", uart_txd); end
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            e = exp_txd(8'h55, 4, k);
            nvec++; if (uart_txd !== e) begin nerr++;
                $display("FAIL frame_txd k=%0d: got %b expected %b", k, uart_txd, e); end
            nvec++; if (s1_rdata[0] !== 1'b1) begin nerr++;
                $display("FAIL frame_busy k=%0d: got %b expected 1", k, s1_rdata[0]); end
            @(posedge clk);
            #1;
        end
        nvec++; if (uart_txd !== 1'b1) begin nerr++;
            $display("FAIL frame_idle_txd: got %b expected 1", uart_txd); end
        nvec++; if (s1_rdata !== 32'h4) begin nerr++;
            $display("FAIL frame_idle_status: got %h expected 00000004", s1_rdata); end
        nvec++; if (irq_o !== 1'b0) begin nerr++;
            $display("FAIL frame_irq: got %b expected 0", irq_o); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) wr(32'h0, 32'(i), 4'h1);
        rd(32'h4, d);
        nvec++; if (d !== 32'h82) begin nerr++;
            $display("FAIL ovf_full: got %h expected 00000082", d); end
        wr(32'h0, 32'hAA, 4'h1);
        rd(32'h4, d);
        nvec++; if (d !== 32'h8A) begin nerr++;
            $display("FAIL ovf_set: got %h expected 0000008a", d); end
        wr(32'h4, 32'h0, 4'hF);
        rd(32'h4, d);
        nvec++; if (d !== 32'h8A) begin nerr++;
            $display("FAIL ovf_w0: got %h expected 0000008a", d); end
        wr(32'h4, 32'h8, 4'hF);
        rd(32'h4, d);
        nvec++; if (d !== 32'h82) begin nerr++;
            $display("FAIL ovf_w1c: got %h expected 00000082", d); end
        // Enable pops the head on the same edge as the next push.
        wr(32'h8, 32'd2, 4'hF);
        wr(32'hC, 32'h1, 4'hF);
        wr(32'h0, 32'h77, 4'h1);
        rd(32'h4, d);
        nvec++; if (d !== 32'h83) begin nerr++;
            $display("FAIL full_push_pop: got %h expected 00000083", d); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic e;
        do_reset();
        wr(32'h8, 32'd2, 4'hF);
        wr(32'h0, 32'hA0, 4'h1);
        wr(32'h0, 32'h0F, 4'h1);
        wr(32'hC, 32'h1, 4'hF);
        s1_raddr = 32'h4;
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            e = (k < 20) ? exp_txd(8'hA0, 2, k) : exp_txd(8'h0F, 2, k - 20);
            nvec++; if (uart_txd !== e) begin nerr++;
                $display("FAIL b2b_txd k=%0d: got %b expected %b", k, uart_txd, e); end
            if (k == 19) begin
                nvec++; if (s1_rdata[2] !== 1'b0) begin nerr++;
                    $display("FAIL b2b_not_empty: got %b expected 0", s1_rdata[2]); end
            end
            if (k == 20) begin
                nvec++; if (s1_rdata[2:0] !== 3'b101) begin nerr++;
                    $display("FAIL b2b_empty_busy: got %b expected 101", s1_rdata[2:0]); end
            end
            @(posedge clk);
            #1;
        end
        nvec++; if (s1_rdata !== 32'h4) begin nerr++;
            $display("FAIL b2b_idle_status: got %h expected 00000004", s1_rdata); end
    endtask

    task automatic test_bauddiv();
        logic [31:0] d;
        logic        e;
        do_reset();
        wr(32'h8, 32'h0, 4'hF);
        rd(32'h8, d);
        nvec++; if (d !== 32'h1) begin nerr++;
            $display("FAIL baud_zero: got %h expected 00000001", d); end
        wr(32'h8, 32'hFFFF_1234, 4'b0010);
        rd(32'h8, d);
        nvec++; if (d !== 32'h1201) begin nerr++;
            $display("FAIL baud_byte_en: got %h expected 00001201", d); end
        rd(32'h0, d);
        nvec++; if (d !== 32'h0) begin nerr++;
            $display("FAIL txdata_read: got %h expected 00000000", d); end
        wr(32'h8, 32'd3, 4'hF);
        wr(32'h0, 32'h33, 4'h1);
        wr(32'h0, 32'hC5, 4'h1);
        wr(32'hC, 32'h1, 4'hF);
        @(posedge clk);
        #1;
        for (int k = 0; k < 110; k++) begin
            s1_we = 4'h0;
            e = (k < 30) ? exp_txd(8'h33, 3, k) : exp_txd(8'hC5, 8, k - 30);
            nvec++; if (uart_txd !== e) begin nerr++;
                $display("FAIL baud_txd k=%0d: got %b expected %b", k, uart_txd, e); end
            if (k == 5) begin
                s1_waddr = 32'h8;
                s1_wdata = 32'd8;
                s1_we    = 4'hF;
            end
            @(posedge clk);
            #1;
        end
        s1_we = 4'h0;
        rd(32'h8, d);
        nvec++; if (d !== 32'h8) begin nerr++;
            $display("FAIL baud_new: got %h expected 00000008", d); end
        rd(32'h4, d);
        nvec++; if (d !== 32'h4) begin nerr++;
            $display("FAIL baud_idle_status: got %h expected 00000004", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        do_reset();
        wr(32'h8, 32'd4, 4'hF);
        wr(32'hC, 32'h1, 4'hF);
        wr(32'h0, 32'h00, 4'h1);
        @(posedge clk);
        #1;
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        nvec++; if (uart_txd !== 1'b0) begin nerr++;
            $display("FAIL mid_bit3: got %b expected 0", uart_txd); end
        #2;
        rst = 1'b1;
        #1;
        nvec++; if (uart_txd !== 1'b1) begin nerr++;
            $display("FAIL mid_async_txd: got %b expected 1", uart_txd); end
        rd(32'h4, d);
        nvec++; if (d !== 32'h4) begin nerr++;
            $display("FAIL mid_status: got %h expected 00000004", d); end
        rd(32'h8, d);
        nvec++; if (d !== 32'd434) begin nerr++;
            $display("FAIL mid_bauddiv: got %h expected %h", d, 32'd434); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        nvec++; if (uart_txd !== 1'b1) begin nerr++;
            $display("FAIL mid_no_resume: got %b expected 1", uart_txd); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [31:0] exp_ctrl;
        logic        exp_irq;
`ifdef UART_TX_IRQ_EN
        exp_ctrl = 32'h3;
        exp_irq  = 1'b1;
`else
        exp_ctrl = 32'h1;
        exp_irq  = 1'b0;
`endif
        do_reset();
        wr(32'hC, 32'h3, 4'hF);
        rd(32'hC, d);
        nvec++; if (d !== exp_ctrl) begin nerr++;
            $display("FAIL irq_ctrl: got %h expected %h", d, exp_ctrl); end
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (irq_o !== exp_irq) begin nerr++;
            $display("FAIL irq_level: got %b expected %b", irq_o, exp_irq); end
        do_reset();
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        rst      = 1'b1;
        s1_waddr = 32'h0;
        s1_wdata = 32'h0;
        s1_we    = 4'h0;
        s1_raddr = 32'h4;
        test_reset();
        test_frame();
        test_overflow();
        test_back_to_back();
        test_bauddiv();
        test_reset_midframe();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
